bus_master_if: RTL

//  Master-side bus interface: the initiator that drives one MxREQ bit of the fixed-priority arbiter and runs bursts once granted.

---
 rtl/bus_master_pkg.sv | 15 +
 rtl/bus_master_if_if.sv | 31 +++
 rtl/bus_master_beat_ctr.sv | 47 ++++
 rtl/bus_master_if.sv | 136 +++++++++++++
 4 files changed

// File: rtl/bus_master_pkg.sv
// Shared types and default widths for the bus master slice.
package bus_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  localparam int unsigned AW_DEF = 32;
  localparam int unsigned DW_DEF = 32;
  localparam int unsigned LW_DEF = 4;

endpackage

// File: rtl/bus_master_if_if.sv
// Shared-bus signal bundle between one master, the arbiter and the addressed slave.
interface bus_master_if_if
  import bus_master_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) ();

  logic          MxREQ;
  logic          AxGNT;
  logic          MmTRANS;
  logic [AW-1:0] MmADDR;
  logic          MmWRITE;
  logic [DW-1:0] MmWDATA;
  logic          MmLK;
  logic          MmLST;
  logic [DW-1:0] MsRDATA;
  logic          MsRDY;
  logic          MsERR;

  modport master (
    output MxREQ, MmTRANS, MmADDR, MmWRITE, MmWDATA, MmLK, MmLST,
    input  AxGNT, MsRDATA, MsRDY, MsERR
  );

  modport slave (
    input  MxREQ, MmTRANS, MmADDR, MmWRITE, MmWDATA, MmLK, MmLST,
    output AxGNT, MsRDATA, MsRDY, MsERR
  );

endinterface

// File: rtl/bus_master_beat_ctr.sv
// Beat address incrementer (wraps at 2**AW) and remaining-beat down-counter.
module bus_master_beat_ctr #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned LW = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] load_addr,
  input  logic [LW-1:0] load_len,
  output logic [AW-1:0] addr,
  output logic          last
);

  localparam logic [AW-1:0] STEP = AW'(DW / 8);

  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] cnt_q, cnt_d;

  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (load) begin
      addr_d = load_addr;
      cnt_d  = load_len;
    end else if (step) begin
      addr_d = addr_q + STEP;
      cnt_d  = cnt_q - LW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign addr = addr_q;
  assign last = (cnt_q == '0);

endmodule

// File: rtl/bus_master_if.sv
// Bus master: accepts client burst commands, arbitrates for the bus, runs beats, optional lock hold.
module bus_master_if
  import bus_master_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned LW = LW_DEF
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [AW-1:0]   cmd_addr,
  input  logic            cmd_write,
  input  logic [LW-1:0]   cmd_len,
  input  logic            cmd_lock,
  input  logic [DW-1:0]   wr_data,
  input  logic            wr_valid,
  output logic            wr_ready,
  output logic [DW-1:0]   rd_data,
  output logic            rd_valid,
  output logic            done,
  output logic            err,
  bus_master_if_if.master bus
);

  state_e        state_q, state_d;
  logic          lock_q, lock_d;
  logic          write_q, write_d;
  logic          pend_q, pend_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          in_xfer, trans, beat_ok, abort, accept, last;
  logic [AW-1:0] beat_addr;

  assign in_xfer = (state_q == ST_XFER);
  assign trans   = in_xfer & (write_q ? wr_valid : 1'b1);
  assign beat_ok = trans & bus.MsRDY & ~bus.MsERR;
  assign abort   = in_xfer & bus.MsERR;
  // A locked owner may take a new command only while it still holds the grant.
  assign accept  = cmd_valid & ((state_q == ST_IDLE) | ((state_q == ST_HOLD) & bus.AxGNT));

  bus_master_beat_ctr #(.AW(AW), .DW(DW), .LW(LW)) u_ctr (
    .CLK       (CLK),
    .RST       (RST),
    .load      (accept),
    .step      (beat_ok),
    .load_addr (cmd_addr),
    .load_len  (cmd_len),
    .addr      (beat_addr),
    .last      (last)
  );

  always_comb begin
    state_d    = state_q;
    lock_d     = lock_q;
    write_d    = write_q;
    pend_d     = pend_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = beat_ok & ~write_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    if (rd_valid_d) rd_data_d = bus.MsRDATA;
    if (accept) begin
      lock_d  = cmd_lock;
      write_d = cmd_write;
      pend_d  = 1'b1;
    end
    unique case (state_q)
      ST_IDLE: if (cmd_valid) state_d = ST_REQ;
      // pend_q distinguishes a resumed burst from a lock owner that lost the grant.
      ST_REQ:  if (bus.AxGNT) state_d = pend_q ? ST_XFER : ST_HOLD;
      ST_XFER: begin
        if (abort) begin
          state_d = ST_IDLE;
          lock_d  = 1'b0;
          pend_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (beat_ok && last) begin
          state_d = lock_q ? ST_HOLD : ST_IDLE;
          pend_d  = 1'b0;
          done_d  = 1'b1;
        end else if (!bus.AxGNT) begin
          state_d = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (!bus.AxGNT)    state_d = ST_REQ;
        else if (cmd_valid) state_d = ST_XFER;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      lock_q     <= 1'b0;
      write_q    <= 1'b0;
      pend_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_q     <= lock_d;
      write_q    <= write_d;
      pend_q     <= pend_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign cmd_ready   = accept;
  assign wr_ready    = beat_ok & write_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign done        = done_q;
  assign err         = err_q;

  assign bus.MxREQ   = (state_q != ST_IDLE);
  assign bus.MmTRANS = trans;
  assign bus.MmADDR  = in_xfer ? beat_addr : '0;
  assign bus.MmWRITE = in_xfer & write_q;
  assign bus.MmWDATA = (in_xfer & write_q) ? wr_data : '0;
  assign bus.MmLK    = lock_q & (in_xfer | (state_q == ST_HOLD));
  assign bus.MmLST   = trans & last;

endmodule
